// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// flush-penalty limits and the load-use dependency test.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam int BRANCH_PENALTY_DEFAULT = 2;
  localparam int BRANCH_PENALTY_MIN     = 1;
  localparam int BRANCH_PENALTY_MAX     = 4;

  // Wide enough for the largest remaining-flush count (MAX-1).
  localparam int CNT_W = 2;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  function automatic logic load_use_hit(
    input logic       fd_valid,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       de_valid,
    input logic [4:0] rd,
    input logic       mem_read
  );
    return fd_valid & de_valid & mem_read & (rd != 5'd0) &
           ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter with synchronous clear and saturation at all-ones.
module sat_counter32
  import hazard_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Clear wins over increment; the count sticks at the top value.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != COUNT_MAX)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory-wait stalls, branch/jump flush
// sequencing and load-use interlock, plus stall/flush event counters.
//
// state     | meaning
// RUN       | normal issue; taken branches and load-use are resolved here
// FLUSH     | fetch/decode is bubbled while the remaining penalty drains
// MEM_WAIT  | whole front end held for data memory; penalty count is kept
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int BRANCH_PENALTY = BRANCH_PENALTY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fd_valid_i,
  input  logic [4:0]  fd_rs1_i,
  input  logic [4:0]  fd_rs2_i,
  input  logic        de_valid_i,
  input  logic [4:0]  de_rd_i,
  input  logic        de_mem_read_i,
  input  logic        ex_branch_taken_i,
  input  logic        ex_jump_i,
  input  logic        mem_busy_i,
  input  logic        counter_clear_i,
  output logic        pc_stall_o,
  output logic        fd_stall_o,
  output logic        de_stall_o,
  output logic        fd_flush_o,
  output logic        de_flush_o,
  output logic        em_stall_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_count_o,
  output logic [31:0] flush_count_o
);

  // Out-of-range penalties are pulled back into the legal window.
  localparam int PENALTY_EFF =
    (BRANCH_PENALTY < BRANCH_PENALTY_MIN) ? BRANCH_PENALTY_MIN :
    (BRANCH_PENALTY > BRANCH_PENALTY_MAX) ? BRANCH_PENALTY_MAX :
    BRANCH_PENALTY;
  localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(PENALTY_EFF - 1);
  localparam state_t           AFTER_TAKEN = (PENALTY_EFF > 1) ? ST_FLUSH : ST_RUN;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken;
  logic             load_use;
  logic             flush_inc;
  logic             eval_run;
  logic             eval_flush;

  assign taken    = de_valid_i & (ex_branch_taken_i | ex_jump_i);
  assign load_use = load_use_hit(fd_valid_i, fd_rs1_i, fd_rs2_i,
                                 de_valid_i, de_rd_i, de_mem_read_i);

  // Leaving MEM_WAIT resumes whichever mode the preserved count implies.
  assign eval_run   = (state_q == ST_RUN)   || ((state_q == ST_MEM_WAIT) && (cnt_q == '0));
  assign eval_flush = (state_q == ST_FLUSH) || ((state_q == ST_MEM_WAIT) && (cnt_q != '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = ST_RUN;
    cnt_d      = cnt_q;
    pc_stall_o = 1'b0;
    fd_stall_o = 1'b0;
    de_stall_o = 1'b0;
    em_stall_o = 1'b0;
    fd_flush_o = 1'b0;
    de_flush_o = 1'b0;
    flush_inc  = 1'b0;

    if (rst_i) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (mem_busy_i) begin
      pc_stall_o = 1'b1;
      fd_stall_o = 1'b1;
      de_stall_o = 1'b1;
      em_stall_o = 1'b1;
      state_d    = ST_MEM_WAIT;
    end else if (eval_flush) begin
      fd_flush_o = 1'b1;
      if (taken) begin
        de_flush_o = 1'b1;
        flush_inc  = 1'b1;
        cnt_d      = RELOAD;
        state_d    = AFTER_TAKEN;
      end else if (cnt_q <= CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = ST_FLUSH;
      end
    end else if (eval_run) begin
      if (taken) begin
        fd_flush_o = 1'b1;
        de_flush_o = 1'b1;
        flush_inc  = 1'b1;
        cnt_d      = RELOAD;
        state_d    = AFTER_TAKEN;
      end else if (load_use) begin
        pc_stall_o = 1'b1;
        fd_stall_o = 1'b1;
        de_flush_o = 1'b1;
        state_d    = ST_RUN;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end
  end

  assign state_o = state_q;

  sat_counter32 u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (counter_clear_i),
    .inc_i   (pc_stall_o),
    .count_o (stall_count_o)
  );

  sat_counter32 u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (counter_clear_i),
    .inc_i   (flush_inc),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed hazard scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int P = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fd_valid_i;
  logic [4:0]  fd_rs1_i;
  logic [4:0]  fd_rs2_i;
  logic        de_valid_i;
  logic [4:0]  de_rd_i;
  logic        de_mem_read_i;
  logic        ex_branch_taken_i;
  logic        ex_jump_i;
  logic        mem_busy_i;
  logic        counter_clear_i;
  logic        pc_stall_o;
  logic        fd_stall_o;
  logic        de_stall_o;
  logic        fd_flush_o;
  logic        de_flush_o;
  logic        em_stall_o;
  logic [1:0]  state_o;
  logic [31:0] stall_count_o;
  logic [31:0] flush_count_o;

  hazard_control_unit #(.BRANCH_PENALTY(P)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .fd_valid_i        (fd_valid_i),
    .fd_rs1_i          (fd_rs1_i),
    .fd_rs2_i          (fd_rs2_i),
    .de_valid_i        (de_valid_i),
    .de_rd_i           (de_rd_i),
    .de_mem_read_i     (de_mem_read_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_jump_i         (ex_jump_i),
    .mem_busy_i        (mem_busy_i),
    .counter_clear_i   (counter_clear_i),
    .pc_stall_o        (pc_stall_o),
    .fd_stall_o        (fd_stall_o),
    .de_stall_o        (de_stall_o),
    .fd_flush_o        (fd_flush_o),
    .de_flush_o        (de_flush_o),
    .em_stall_o        (em_stall_o),
    .state_o           (state_o),
    .stall_count_o     (stall_count_o),
    .flush_count_o     (flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: extra fetch/decode bubbles still owed, whether memory is being
  // waited on, and the two event tallies.
  int          m_left = 0;
  bit          m_wait = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  // Inputs are already driven; check the combinational response, advance
  // the model across the clock edge, then check registered outputs.
  task automatic step();
    logic [5:0] exp_ctl;
    bit taken, lu, flinc;
    taken = de_valid_i && (ex_branch_taken_i || ex_jump_i);
    lu    = fd_valid_i && de_valid_i && de_mem_read_i && (de_rd_i != 0) &&
            ((de_rd_i == fd_rs1_i) || (de_rd_i == fd_rs2_i));
    exp_ctl = 6'b0;
    flinc   = 1'b0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        exp_ctl = 6'b111100;
      end else begin
        if (m_left > 0) exp_ctl[1] = 1'b1;
        if (taken) begin
          exp_ctl[1] = 1'b1;
          exp_ctl[0] = 1'b1;
          flinc      = 1'b1;
        end else if (m_left == 0 && lu) begin
          exp_ctl = 6'b110001;
        end
      end
    end
    @(negedge clk_i);
    check("ctl", 32'({pc_stall_o, fd_stall_o, de_stall_o, em_stall_o, fd_flush_o, de_flush_o}),
          32'(exp_ctl));
    if (rst_i) begin
      m_left  = 0;
      m_wait  = 1'b0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (mem_busy_i) begin
        m_wait = 1'b1;
      end else begin
        m_wait = 1'b0;
        if (taken) m_left = P - 1;
        else if (m_left > 0) m_left--;
      end
      if (counter_clear_i) begin
        m_stall = '0;
        m_flush = '0;
      end else begin
        if (exp_ctl[5] && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (flinc && m_flush != 32'hFFFF_FFFF) m_flush++;
      end
    end
    @(posedge clk_i);
    #1;
    check("state", 32'(state_o), m_wait ? 32'd2 : (m_left > 0 ? 32'd1 : 32'd0));
    check("stall_count", stall_count_o, m_stall);
    check("flush_count", flush_count_o, m_flush);
  endtask

  task automatic idle_inputs();
    rst_i             = 1'b0;
    fd_valid_i        = 1'b0;
    fd_rs1_i          = 5'd0;
    fd_rs2_i          = 5'd0;
    de_valid_i        = 1'b0;
    de_rd_i           = 5'd0;
    de_mem_read_i     = 1'b0;
    ex_branch_taken_i = 1'b0;
    ex_jump_i         = 1'b0;
    mem_busy_i        = 1'b0;
    counter_clear_i   = 1'b0;
  endtask

  task automatic clear_counters();
    idle_inputs();
    counter_clear_i = 1'b1;
    step();
    counter_clear_i = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    fd_valid_i    = 1'b1;
    fd_rs1_i      = rs1;
    fd_rs2_i      = rs2;
    de_valid_i    = 1'b1;
    de_rd_i       = rd;
    de_mem_read_i = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    step();
    step();
    check("reset_state", 32'(state_o), 32'd0);
    rst_i = 1'b0;

    // Load into x0 with a dependent rs2 = x0: no interlock.
    set_load_use(5'd0, 5'd3, 5'd0);
    step();
    check("x0_no_stall", stall_count_o, 32'd0);

    // Load x5 followed by a use of x5 in rs1.
    idle_inputs();
    set_load_use(5'd5, 5'd5, 5'd7);
    step();
    idle_inputs();
    step();
    check("load_use_count", stall_count_o, 32'd1);

    // Taken branch with the default penalty.
    clear_counters();
    de_valid_i        = 1'b1;
    ex_branch_taken_i = 1'b1;
    step();
    check("branch_state_flush", 32'(state_o), 32'd1);
    idle_inputs();
    step();
    check("branch_state_run", 32'(state_o), 32'd0);
    check("branch_flush_count", flush_count_o, 32'd1);

    // Memory wait of three cycles while one flush cycle is still owed.
    clear_counters();
    de_valid_i = 1'b1;
    ex_jump_i  = 1'b1;
    step();
    idle_inputs();
    mem_busy_i = 1'b1;
    repeat (3) step();
    mem_busy_i = 1'b0;
    step();
    step();
    check("memwait_stall_count", stall_count_o, 32'd3);

    // Branch and load-use together: the branch wins.
    clear_counters();
    set_load_use(5'd9, 5'd1, 5'd9);
    ex_branch_taken_i = 1'b1;
    step();
    idle_inputs();
    step();
    check("branch_over_lu", stall_count_o, 32'd0);

    // Saturation from a preset value close to the top.
    force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
    force dut.u_flush_cnt.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.count_q;
    release dut.u_flush_cnt.count_q;
    m_stall = 32'hFFFF_FFFE;
    m_flush = 32'hFFFF_FFFF;
    set_load_use(5'd5, 5'd5, 5'd0);
    repeat (3) step();
    check("stall_saturated", stall_count_o, 32'hFFFF_FFFF);
    idle_inputs();
    de_valid_i = 1'b1;
    ex_jump_i  = 1'b1;
    step();
    check("flush_saturated", flush_count_o, 32'hFFFF_FFFF);
    idle_inputs();
    counter_clear_i = 1'b1;
    step();
    check("clear_stall", stall_count_o, 32'd0);
    check("clear_flush", flush_count_o, 32'd0);

    // Reset abandons a flush sequence and a memory wait.
    idle_inputs();
    de_valid_i        = 1'b1;
    ex_branch_taken_i = 1'b1;
    step();
    idle_inputs();
    rst_i = 1'b1;
    step();
    check("rst_mid_flush", 32'(state_o), 32'd0);
    idle_inputs();
    de_valid_i = 1'b1;
    ex_jump_i  = 1'b1;
    step();
    idle_inputs();
    mem_busy_i = 1'b1;
    step();
    rst_i = 1'b1;
    step();
    check("rst_mid_wait", 32'(state_o), 32'd0);
    idle_inputs();
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_i             = ($urandom_range(0, 59) == 0);
      counter_clear_i   = ($urandom_range(0, 49) == 0);
      fd_valid_i        = ($urandom_range(0, 3) != 0);
      fd_rs1_i          = 5'($urandom_range(0, 3));
      fd_rs2_i          = 5'($urandom_range(0, 3));
      de_valid_i        = ($urandom_range(0, 3) != 0);
      de_rd_i           = 5'($urandom_range(0, 3));
      de_mem_read_i     = ($urandom_range(0, 1) == 0);
      ex_branch_taken_i = ($urandom_range(0, 7) == 0);
      ex_jump_i         = ($urandom_range(0, 11) == 0);
      mem_busy_i        = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: BRANCH_PENALTY, default 2, number of cycles fd_flush_o stays high after a taken branch or jump; legal range 1..4.
REQ-002 Clocking SHALL be one clock, clk_i; reset SHALL be synchronous and active-high, rst_i.
REQ-003 clk_i  in  1  pipeline clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 fd_valid_i  in  1  fetch/decode register holds a valid instruction.
REQ-006 fd_rs1_i, fd_rs2_i  in  5 each  source registers of the instruction in decode.
REQ-007 de_valid_i  in  1  decode/execute register holds a valid instruction.
REQ-008 de_rd_i  in  5  destination register of the instruction in execute.
REQ-009 de_mem_read_i  in  1  instruction in execute is a load.
REQ-010 ex_branch_taken_i, ex_jump_i  in  1 each  execute stage resolved a taken branch or jump.
REQ-011 mem_busy_i  in  1  data memory not ready; the memory stage must hold.
REQ-012 counter_clear_i  in  1  synchronous clear of both performance counters.
REQ-013 pc_stall_o, fd_stall_o, de_stall_o  out  1 each  hold PC, fetch/decode register, decode/execute register.
REQ-014 fd_flush_o, de_flush_o  out  1 each  load a bubble into fetch/decode or decode/execute register.
REQ-015 em_stall_o  out  1  hold execute/memory register.
REQ-016 state_o  out  2  current FSM state encoding.
REQ-017 stall_count_o, flush_count_o  out  32 each  saturating performance counters.

Function
REQ-018 FSM states SHALL be RUN=0, FLUSH=1, MEM_WAIT=2; encoding 3 unused and SHALL return to RUN.
REQ-019 Stall/flush outputs SHALL be combinational from state and current inputs (zero-cycle latency); state_o and counters are registered.
REQ-020 Event priority SHALL be mem_busy_i > (taken = ex_branch_taken_i|ex_jump_i qualified by de_valid_i) > load-use.
REQ-021 load_use SHALL be true when fd_valid_i & de_valid_i & de_mem_read_i & de_rd_i!=0 & (de_rd_i==fd_rs1_i | de_rd_i==fd_rs2_i).
REQ-022 Any state, mem_busy_i=1: pc_stall_o, fd_stall_o, de_stall_o, em_stall_o =1, all flushes =0, next state MEM_WAIT; a remaining FLUSH count SHALL be preserved.
REQ-023 MEM_WAIT, mem_busy_i=0: evaluate as RUN this cycle if preserved count is 0, else as FLUSH.
REQ-024 RUN, taken: fd_flush_o=1, de_flush_o=1, no stalls; flush_count increments once; if BRANCH_PENALTY>1 load count BRANCH_PENALTY-1 and go FLUSH.
REQ-025 RUN, load_use without taken: pc_stall_o=1, fd_stall_o=1, de_flush_o=1 for exactly one cycle; state stays RUN.
REQ-026 FLUSH: fd_flush_o=1, load-use detection suppressed, count decrements; at count reaching 0 return to RUN; a new taken event reloads the count and increments flush_count.
REQ-027 stall_count SHALL increment every cycle pc_stall_o=1; both counters saturate at 0xFFFFFFFF; counter_clear_i has priority over increment.
REQ-028 de_rd_i==0 SHALL never produce a load-use stall.

Reset
REQ-029 While rst_i=1: state RUN, flush count 0, both counters 0, all stall and flush outputs 0.
REQ-030 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abandon the sequence; first post-reset cycle evaluates from RUN.

Structure
REQ-031 Package hazard_pkg SHALL hold the state encoding and BRANCH_PENALTY default/limits.
REQ-032 One sub-module sat_counter32 (clear, increment, saturate) SHALL be instantiated twice.

Verification
REQ-033 Load x5, next instruction uses rs1=x5 -> one cycle pc_stall_o=fd_stall_o=de_flush_o=1, stall_count=1.
REQ-034 Load to x0, dependent rs2=x0 -> no stall, stall_count stays 0.
REQ-035 Branch taken, BRANCH_PENALTY=2 -> fd_flush_o high 2 cycles, de_flush_o 1 cycle, flush_count=1, state_o 0->1->0.
REQ-036 mem_busy_i high 3 cycles during FLUSH with count 1 -> 3 cycles all stalls, then 1 cycle fd_flush_o, then RUN; stall_count=3.
REQ-037 Branch and load-use same cycle -> flushes only, no stall, stall_count unchanged.
REQ-038 Counters preset near 0xFFFFFFFF -> saturate; counter_clear_i -> 0 next cycle; rst_i mid-FLUSH -> state_o=0.
